fetch_unit: RTL and testbench

Instruction-fetch stage for the 32-bit ARM-subset CPU. Owns the program counter, issues word fetches to instruction memory over a request/valid handshake, and holds the fetched word in an instruction register. That register drives the controller's Instr[31:12] input and the datapath's register/immediate fields. At the end of each execute cycle it takes the next PC as either the sequential PC+4 or the branch/PC-write target selected by the controller's PCSrc.

---
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/rvalid
// handshake into the instruction register and retires on each unstalled EXEC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] RETIRED_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] PCPlus8,
  output logic [31:0] retired_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;

  // Next-state, PC, IR and retire counter; handshake flags follow the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d    = PCSrc ? (Result & WORD_MASK) : (pc_q + XLEN'(4));
          cnt_d   = cnt_q + XLEN'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_EXEC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= RETIRED_INIT;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign instr_valid   = valid_q;
  assign Instr         = ir_q;
  assign PC            = pc_q;
  assign PCPlus4       = pc_q + XLEN'(4);
  assign PCPlus8       = pc_q + XLEN'(8);
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a
// phase-level reference model of the fetch/execute protocol.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, pcsrc, stall, rvalid;
  logic [31:0] result, rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pc4, pc8, cnt;

  // Second instance starts near the top of both the address and count ranges.
  logic        w_reset;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_pc8, w_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = boot, 1 = fetch, 2 = execute.
  int          m_phase;
  logic [31:0] m_pc, m_ir, m_cnt;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .PCSrc(pcsrc), .Result(result), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(rvalid),
    .imem_rdata(rdata), .Instr(instr), .instr_valid(instr_valid), .PC(pc),
    .PCPlus4(pc4), .PCPlus8(pc8), .retired_count(cnt)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .RETIRED_INIT(32'hFFFF_FFFE)) dut_w (
    .clk(clk), .reset(w_reset), .PCSrc(1'b0), .Result(32'h0), .stall(1'b0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(1'b1),
    .imem_rdata(32'hE1A0_0000), .Instr(w_instr), .instr_valid(w_valid), .PC(w_pc),
    .PCPlus4(w_pc4), .PCPlus8(w_pc8), .retired_count(w_cnt)
  );

  // Advance one clock edge, updating the model with the inputs the DUT saw.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_pc = RST_PC; m_ir = 32'h0; m_cnt = 32'h0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (rvalid) begin m_ir = rdata; m_phase = 2; end
    end else if (!stall) begin
      m_pc = pcsrc ? {result[31:2], 2'b00} : m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      m_phase = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; pcsrc = 0; stall = 0; rvalid = 0; result = 0; rdata = 0;
    cycle(); cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h100 || pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h/%h want 100", imem_addr, pc); end
    checks++; if (pc4 !== 32'h104 || pc8 !== 32'h108) begin errors++; $display("FAIL reset_pcplus got %h/%h want 104/108", pc4, pc8); end
    checks++; if (instr !== 32'h0 || cnt !== 32'h0) begin errors++; $display("FAIL reset_ir_cnt got %h/%h want 0/0", instr, cnt); end
    // Release reset; the boot cycle must ignore a response.
    reset = 0; rvalid = 1; rdata = 32'hBAD0_0BAD;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b want 0", imem_req); end
    cycle();
    rvalid = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL first_req got %b@%h want 1@100", imem_req, imem_addr); end
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL boot_rvalid got %h/%b want 0/0", instr, instr_valid); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] words [3];
    words[0] = 32'hE080_0001; words[1] = 32'hE080_0002; words[2] = 32'hE080_0003;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1; rdata = words[i];
      cycle();
      rvalid = 0;
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL zw_exec%0d got v=%b r=%b want v=1 r=0", i, instr_valid, imem_req); end
      checks++; if (instr !== words[i]) begin errors++; $display("FAIL zw_instr%0d got %h want %h", i, instr, words[i]); end
      checks++; if (pc !== 32'h100 + 32'(4 * i) || pc8 !== 32'h108 + 32'(4 * i)) begin errors++; $display("FAIL zw_pc%0d got %h/%h want %h/%h", i, pc, pc8, 32'h100 + 32'(4 * i), 32'h108 + 32'(4 * i)); end
      cycle();
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL zw_fetch%0d got v=%b r=%b want v=0 r=1", i, instr_valid, imem_req); end
    end
    checks++; if (cnt !== 32'd3) begin errors++; $display("FAIL zw_count got %0d want 3", cnt); end
  endtask

  task automatic test_wait_states();
    logic [31:0] old_ir;
    old_ir = instr;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C || instr !== old_ir) begin errors++; $display("FAIL ws_hold%0d got r=%b a=%h i=%h want r=1 a=10c i=%h", i, imem_req, imem_addr, instr, old_ir); end
      if (i < 3) cycle();
    end
    rvalid = 1; rdata = 32'hE591_0004;
    cycle();
    checks++; if (instr !== 32'hE591_0004 || instr_valid !== 1'b1) begin errors++; $display("FAIL ws_load got %h/%b want e5910004/1", instr, instr_valid); end
    stall = 1; rdata = 32'h1234_5678;
    cycle();
    checks++; if (instr !== 32'hE591_0004) begin errors++; $display("FAIL ws_spurious got %h want e5910004", instr); end
    checks++; if (pc !== 32'h10C || cnt !== 32'd3 || instr_valid !== 1'b1) begin errors++; $display("FAIL ws_stall got pc=%h c=%0d v=%b want 10c 3 1", pc, cnt, instr_valid); end
    stall = 0; rvalid = 0;
    cycle();
    checks++; if (pc !== 32'h110 || cnt !== 32'd4) begin errors++; $display("FAIL ws_retire got pc=%h c=%0d want 110 4", pc, cnt); end
  endtask

  task automatic exec_and_retire(input logic sel, input logic [31:0] tgt);
    rvalid = 1; rdata = 32'hEA00_0000;
    cycle();
    rvalid = 0; pcsrc = sel; result = tgt;
    cycle();
    pcsrc = 0;
  endtask

  task automatic test_branch();
    logic [31:0] c0;
    exec_and_retire(1'b1, 32'h200);
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL br_setup got %h want 200", imem_addr); end
    exec_and_retire(1'b1, 32'h0000_0403);
    checks++; if (imem_addr !== 32'h400 || imem_req !== 1'b1) begin errors++; $display("FAIL br_target got %h/%b want 400/1", imem_addr, imem_req); end
    exec_and_retire(1'b1, 32'h200);
    rvalid = 1; cycle(); rvalid = 0;
    c0 = cnt;
    stall = 1; pcsrc = 1; result = 32'h600;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (pc !== 32'h200 || cnt !== c0 || instr_valid !== 1'b1) begin errors++; $display("FAIL br_stall%0d got pc=%h c=%0d v=%b want 200 %0d 1", i, pc, cnt, instr_valid, c0); end
    end
    stall = 0; result = 32'h403;
    cycle();
    pcsrc = 0;
    checks++; if (pc !== 32'h400 || cnt !== c0 + 32'd1) begin errors++; $display("FAIL br_release got pc=%h c=%0d want 400 %0d", pc, cnt, c0 + 32'd1); end
  endtask

  task automatic test_wrap();
    exec_and_retire(1'b1, 32'hFFFF_FFFF);
    rvalid = 1; cycle(); rvalid = 0;
    checks++; if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0 || pc8 !== 32'h4) begin errors++; $display("FAIL wrap_plus got %h/%h/%h want fffffffc/0/4", pc, pc4, pc8); end
    cycle();
    checks++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", pc); end
  endtask

  task automatic test_reset_mid_fetch();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmf_precond got %b want 1", imem_req); end
    reset = 1; rvalid = 1; rdata = 32'hDEAD_BEEF;
    cycle();
    reset = 0; rvalid = 0;
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rmf_state got i=%h v=%b r=%b want 0 0 0", instr, instr_valid, imem_req); end
    checks++; if (pc !== RST_PC || cnt !== 32'h0) begin errors++; $display("FAIL rmf_pc got %h/%0d want 100/0", pc, cnt); end
    cycle();
    checks++; if (instr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL rmf_boot got i=%h r=%b want 0 1", instr, imem_req); end
  endtask

  task automatic test_count_wrap();
    w_reset = 1;
    @(posedge clk); #1;
    w_reset = 0;
    checks++; if (w_cnt !== 32'hFFFF_FFFE || w_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL cw_init got %h/%h want fffffffe/fffffff8", w_cnt, w_pc); end
    repeat (3) @(posedge clk); #1;
    checks++; if (w_cnt !== 32'hFFFF_FFFF || w_pc !== 32'hFFFF_FFFC || w_req !== 1'b1) begin errors++; $display("FAIL cw_mid got %h/%h/%b want ffffffff/fffffffc/1", w_cnt, w_pc, w_req); end
    @(posedge clk); #1;
    checks++; if (w_valid !== 1'b1 || w_pc8 !== 32'h4 || w_instr !== 32'hE1A0_0000) begin errors++; $display("FAIL cw_exec got %b/%h/%h want 1/4/e1a00000", w_valid, w_pc8, w_instr); end
    @(posedge clk); #1;
    checks++; if (w_cnt !== 32'h0 || w_pc !== 32'h0 || w_addr !== 32'h0) begin errors++; $display("FAIL cw_wrap got %h/%h want 0/0", w_cnt, w_pc); end
    w_reset = 1;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(99) < 2);
      rvalid = ($urandom_range(1) == 1);
      stall  = ($urandom_range(9) < 3);
      pcsrc  = ($urandom_range(3) == 0);
      result = $urandom;
      rdata  = $urandom;
      cycle();
      checks++;
      if (imem_req !== (m_phase == 1) || instr_valid !== (m_phase == 2) ||
          pc !== m_pc || imem_addr !== m_pc || pc4 !== m_pc + 32'd4 ||
          pc8 !== m_pc + 32'd8 || instr !== m_ir || cnt !== m_cnt) begin
        errors++;
        if (bad < 10) $display("FAIL rand@%0d got r=%b v=%b pc=%h ir=%h c=%h want r=%b v=%b pc=%h ir=%h c=%h",
                               i, imem_req, instr_valid, pc, instr, cnt,
                               m_phase == 1, m_phase == 2, m_pc, m_ir, m_cnt);
        bad++;
      end
    end
    reset = 0; stall = 0; pcsrc = 0; rvalid = 0;
  endtask

  initial begin
    w_reset = 1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_wrap();
    test_reset_mid_fetch();
    test_count_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
